// File: rtl/vga_pkg.sv
// Register map shared with the VGA peripheral, and the fill-engine state encoding.
package vga_pkg;

   localparam logic [31:0] EN           = 32'h00;
   localparam logic [31:0] X_ADDR       = 32'h04;
   localparam logic [31:0] Y_ADDR       = 32'h08;
   localparam logic [31:0] DATA         = 32'h0c;
   localparam logic [31:0] PALETTE_ADDR = 32'h10;
   localparam logic [31:0] COLOR        = 32'h14;
   localparam logic [31:0] SCANLINE     = 32'h18;

   typedef enum logic [2:0] {
      IDLE,
      SET_X,
      SET_Y,
      FILL,
      DONE
   } TFillState_e;

endpackage

// File: rtl/vga_rect_fill_if.sv
// Write channel of the Simple_Worker_Mem bus, seen from a master or a slave.
interface vga_rect_fill_if;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_byteEn;
   logic        wr_valid;
   logic        wr_ready;

   modport master (
      output wr_addr,
      output wr_data,
      output wr_byteEn,
      output wr_valid,
      input  wr_ready
   );

   modport slave (
      input  wr_addr,
      input  wr_data,
      input  wr_byteEn,
      input  wr_valid,
      output wr_ready
   );
endinterface

// File: rtl/vga_bus_write_port.sv
// Single-transfer write requester: load latches one address/data pair, complete pulses on accept.
module vga_bus_write_port (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [31:0]      load_addr,
   input  logic [31:0]      load_data,
   output logic             req,
   output logic             complete,
   vga_rect_fill_if.master  bus
);

   logic [31:0] addr_q;
   logic [31:0] data_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         req    <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else if (complete) begin
         req <= 1'b0;
      end else if (load && !req) begin
         req    <= 1'b1;
         addr_q <= load_addr;
         data_q <= load_data;
      end
   end

   // The peripheral accepts over two cycles; dropping valid while ready is high avoids a repeat write.
   assign complete      = req & bus.wr_ready;
   assign bus.wr_valid  = req & ~bus.wr_ready;
   assign bus.wr_addr   = addr_q;
   assign bus.wr_data   = data_q;
   assign bus.wr_byteEn = req ? 4'hF : 4'h0;

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: turns one (x, y, w, h, color) command into VGA register writes.
//
//  state | meaning
//  IDLE  | waiting for a command, cmd_ready high
//  SET_X | write X_ADDR with the left column (empty commands leave from here)
//  SET_Y | write Y_ADDR with the current row
//  FILL  | write DATA once per pixel, peripheral auto-increments X
//  DONE  | one-cycle done pulse, aborted qualifies it
module vga_rect_fill
   import vga_pkg::*;
#(
   parameter logic [31:0] VGA_ADDR   = 32'h1000_0000,
   parameter int          MAX_W      = 640,
   parameter int          MAX_H      = 480,
   parameter int          COLOR_BITS = 24
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [10:0]           cmd_x,
   input  logic [9:0]            cmd_y,
   input  logic [10:0]           cmd_w,
   input  logic [9:0]            cmd_h,
   input  logic [COLOR_BITS-1:0] cmd_color,
   input  logic                  abort,
   vga_rect_fill_if.master       bus,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted
);

   localparam logic [11:0] MAX_W12 = 12'(MAX_W);
   localparam logic [10:0] MAX_H11 = 11'(MAX_H);

   TFillState_e           state;
   logic [10:0]           x_q;
   logic [9:0]            y_q;
   logic [COLOR_BITS-1:0] color_q;
   logic [10:0]           we_q;
   logic [9:0]            he_q;
   logic [10:0]           col;
   logic [9:0]            row;
   logic                  abort_q;

   logic [11:0] room_w;
   logic [10:0] room_h;
   logic        over_w;
   logic        over_h;
   logic [10:0] we_c;
   logic [9:0]  he_c;

   logic        xfer;
   logic        stop;
   logic        empty;
   logic        halt;
   logic        load;
   logic        req;
   logic        complete;
   logic [31:0] load_addr;
   logic [31:0] load_data;

   // Clipping keeps col/row in range, so the peripheral's own X wrap is never hit.
   assign room_w = MAX_W12 - {1'b0, cmd_x};
   assign room_h = MAX_H11 - {1'b0, cmd_y};
   assign over_w = {1'b0, cmd_x} >= MAX_W12;
   assign over_h = {1'b0, cmd_y} >= MAX_H11;
   assign we_c   = over_w ? 11'd0 : (({1'b0, cmd_w} < room_w) ? cmd_w : room_w[10:0]);
   assign he_c   = over_h ? 10'd0 : (({1'b0, cmd_h} < room_h) ? cmd_h : room_h[9:0]);

   assign busy      = (state != IDLE);
   assign cmd_ready = (state == IDLE);

   assign xfer  = (state == SET_X) || (state == SET_Y) || (state == FILL);
   assign stop  = abort_q | abort;
   assign empty = (we_q == 11'd0) || (he_q == 10'd0);
   // An in-flight transfer always finishes before an abort is honoured.
   assign halt  = xfer & stop & (complete | ~req);
   assign load  = xfer & ~req & ~stop & ~empty;

   always_comb begin
      load_addr = VGA_ADDR + X_ADDR;
      load_data = 32'(x_q);
      case (state)
         SET_Y: begin
            load_addr = VGA_ADDR + Y_ADDR;
            load_data = 32'(y_q) + 32'(row);
         end
         FILL: begin
            load_addr = VGA_ADDR + DATA;
            load_data = 32'(color_q);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         color_q <= '0;
         we_q    <= '0;
         he_q    <= '0;
         col     <= '0;
         row     <= '0;
         abort_q <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         if (busy && abort) abort_q <= 1'b1;
         unique case (state)
            IDLE: begin
               abort_q <= 1'b0;
               done    <= 1'b0;
               aborted <= 1'b0;
               if (cmd_valid) begin
                  x_q     <= cmd_x;
                  y_q     <= cmd_y;
                  color_q <= cmd_color;
                  we_q    <= we_c;
                  he_q    <= he_c;
                  col     <= '0;
                  row     <= '0;
                  state   <= SET_X;
               end
            end
            SET_X, SET_Y, FILL: begin
               if (halt || empty) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  aborted <= stop;
               end else if (complete) begin
                  case (state)
                     SET_X: state <= SET_Y;
                     SET_Y: state <= FILL;
                     FILL: begin
                        if (col == we_q - 11'd1) begin
                           col <= '0;
                           row <= row + 10'd1;
                           if (row == he_q - 10'd1) begin
                              state <= DONE;
                              done  <= 1'b1;
                           end else begin
                              state <= SET_X;
                           end
                        end else begin
                           col <= col + 11'd1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            DONE: begin
               done    <= 1'b0;
               aborted <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   vga_bus_write_port u_port (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (load),
      .load_addr (load_addr),
      .load_data (load_data),
      .req       (req),
      .complete  (complete),
      .bus       (bus)
   );

endmodule
